// File: rtl/mux2_arbiter_if.sv
// Bundle between two byte sources and the shared 2:1 mux arbiter.
// master = source/consumer side, slave = arbiter side.
interface mux2_arbiter_if;
  logic       req0;
  logic       req1;
  logic [7:0] I0;
  logic [7:0] I1;
  logic       gnt0;
  logic       gnt1;
  logic       s;
  logic [7:0] o;
  logic       o_valid;

  // Handshake: a source holds reqX high for as long as it wants the bus; gntX
  // is the registered ownership flag, and o/o_valid follow one edge later with
  // the owner's byte. There is no back-pressure from the consumer.
  modport master (
    output req0, req1, I0, I1,
    input  gnt0, gnt1, s, o, o_valid
  );

  modport slave (
    input  req0, req1, I0, I1,
    output gnt0, gnt1, s, o, o_valid
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester byte mux arbiter: round-robin with bounded hold time.
// Define MUX_ARB_FIXED_PRI_EN to make requester 0 the fixed-priority winner.
module mux2_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux2_arbiter_if.slave      bus,
  output logic [1:0]         o_dbg_state
);

  // One-hot owner encoding lets the grants come straight off state flops.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic [HOLD_W-1:0] LP_CNT_LAST = HOLD_W'(HOLD_MAX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] w_cnt_nxt;
  logic              r_s;
  logic              w_s_nxt;
  logic [7:0]        r_o;
  logic [7:0]        w_o_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              w_expired;

`ifndef MUX_ARB_FIXED_PRI_EN
  logic              r_last;
  logic              w_last_nxt;
`endif

  assign w_expired = (r_cnt == LAST_SEL());

  function automatic logic [HOLD_W-1:0] LAST_SEL();
    return LP_CNT_LAST;
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_o     <= 8'h00;
      r_valid <= 1'b0;
`ifndef MUX_ARB_FIXED_PRI_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_o     <= w_o_nxt;
      r_valid <= w_valid_nxt;
`ifndef MUX_ARB_FIXED_PRI_EN
      r_last  <= w_last_nxt;
`endif
    end
  end

  // Next-state logic; only the request lines steer it, never the data bytes.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
`ifdef MUX_ARB_FIXED_PRI_EN
          w_next = ST_OWN0;
`else
          w_next = r_last ? ST_OWN0 : ST_OWN1;
`endif
        end else if (bus.req0) begin
          w_next = ST_OWN0;
        end else if (bus.req1) begin
          w_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!bus.req0) begin
          w_next = bus.req1 ? ST_OWN1 : ST_IDLE;
        end else if (w_expired && bus.req1) begin
`ifdef MUX_ARB_FIXED_PRI_EN
          w_next = ST_OWN0;
`else
          w_next = ST_OWN1;
`endif
        end
      end
      ST_OWN1: begin
        if (!bus.req1) begin
          w_next = bus.req0 ? ST_OWN0 : ST_IDLE;
        end else if (w_expired && bus.req0) begin
          w_next = ST_OWN0;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_s_nxt     = r_s;
    w_o_nxt     = 8'h00;
    w_valid_nxt = 1'b0;
    w_cnt_nxt   = '0;

    if (w_next == ST_OWN1) begin
      w_s_nxt = 1'b1;
    end else if (w_next == ST_OWN0) begin
      w_s_nxt = 1'b0;
    end

    if (r_state == ST_OWN0) begin
      w_o_nxt     = bus.I0;
      w_valid_nxt = 1'b1;
    end else if (r_state == ST_OWN1) begin
      w_o_nxt     = bus.I1;
      w_valid_nxt = 1'b1;
    end

    // Counter restarts on every ownership change and at each hold expiry.
    if ((r_state != ST_IDLE) && (w_next == r_state) && !w_expired) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

`ifndef MUX_ARB_FIXED_PRI_EN
  always_comb begin
    w_last_nxt = r_last;
    if ((r_state == ST_OWN0) && (w_next != ST_OWN0)) begin
      w_last_nxt = 1'b0;
    end else if ((r_state == ST_OWN1) && (w_next != ST_OWN1)) begin
      w_last_nxt = 1'b1;
    end
  end
`endif

  assign bus.gnt0    = r_state[0];
  assign bus.gnt1    = r_state[1];
  assign bus.s       = r_s;
  assign bus.o       = r_o;
  assign bus.o_valid = r_valid;
  assign o_dbg_state = r_state;

endmodule
